// File: rtl/ir_pkg.sv
// ir_pkg: shared types and constants for the IR sampler.
//   state_t  : sequencing FSM states
//   RD_W     : A2D reading width
//   NUM_PAIRS: number of emitter pairs
//   R_CHNL   : A2D channel of the right sensor of each pair
//   L_CHNL   : A2D channel of the left sensor of each pair
package ir_pkg;

    localparam int unsigned RD_W      = 12;
    localparam int unsigned NUM_PAIRS = 4;

    typedef enum logic [2:0] {
        StIdle,
        StSettle,
        StCnvR,
        StWaitR,
        StCnvL,
        StWaitL,
        StDone
    } state_t;

    localparam logic [2:0] R_CHNL [0:3] = '{3'd0, 3'd1, 3'd2, 3'd3};
    localparam logic [2:0] L_CHNL [0:3] = '{3'd4, 3'd5, 3'd6, 3'd7};

endpackage

// File: rtl/ir_sampler_if.sv
// ir_sampler_if: signals between the IR sampler, the A2D block and the error-compute consumer.
//   en                 sampling enable
//   strt_cnv/chnl      conversion request and channel select (to A2D)
//   cnv_cmplt/res      conversion done strobe and result (from A2D)
//   IR_en              one-hot emitter-pair enable
//   IR_R0..3, IR_L0..3 coherent reading set
//   IR_vld             one-cycle strobe: reading set just updated
// Modports: master = sampler side, slave = environment side.
interface ir_sampler_if;
    import ir_pkg::*;

    logic            en;
    logic            strt_cnv;
    logic [2:0]      chnl;
    logic            cnv_cmplt;
    logic [RD_W-1:0] res;
    logic [3:0]      IR_en;
    logic [RD_W-1:0] IR_R0;
    logic [RD_W-1:0] IR_R1;
    logic [RD_W-1:0] IR_R2;
    logic [RD_W-1:0] IR_R3;
    logic [RD_W-1:0] IR_L0;
    logic [RD_W-1:0] IR_L1;
    logic [RD_W-1:0] IR_L2;
    logic [RD_W-1:0] IR_L3;
    logic            IR_vld;

    modport master (
        input  en, cnv_cmplt, res,
        output strt_cnv, chnl, IR_en, IR_R0, IR_R1, IR_R2, IR_R3,
               IR_L0, IR_L1, IR_L2, IR_L3, IR_vld
    );

    modport slave (
        output en, cnv_cmplt, res,
        input  strt_cnv, chnl, IR_en, IR_R0, IR_R1, IR_R2, IR_R3,
               IR_L0, IR_L1, IR_L2, IR_L3, IR_vld
    );

endinterface

// File: rtl/ir_sampler_timer.sv
// ir_sampler_timer: free-running period timer plus a shared settle/timeout down-counter.
//   clk, rst      clock, asynchronous active-high reset
//   i_ld_settle   load the down-counter for an emitter settle interval
//   i_ld_tmo      load the down-counter for a conversion timeout interval
//   o_tick        high for one cycle every PERIOD cycles
//   o_cnt_zero    down-counter has expired
module ir_sampler_timer #(
    parameter int unsigned PERIOD = 65536,
    parameter int unsigned SETTLE = 1024,
    parameter int unsigned TMO    = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic i_ld_settle,
    input  logic i_ld_tmo,
    output logic o_tick,
    output logic o_cnt_zero
);

    localparam int unsigned PER_W  = $clog2(PERIOD);
    localparam int unsigned MAX_LD = (SETTLE > TMO) ? SETTLE : TMO;
    localparam int unsigned CNT_W  = $clog2(MAX_LD + 1);

    logic [PER_W-1:0] r_per;
    logic [CNT_W-1:0] r_cnt;
    logic             w_tick;

    assign w_tick     = (r_per == PER_W'(PERIOD - 1));
    assign o_tick     = w_tick;
    assign o_cnt_zero = (r_cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_per <= '0;
        end else if (w_tick) begin
            r_per <= '0;
        end else begin
            r_per <= r_per + PER_W'(1);
        end
    end

    // Loaded with N-1 so the owning state lasts exactly N cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_ld_settle) begin
            r_cnt <= CNT_W'(SETTLE - 1);
        end else if (i_ld_tmo) begin
            r_cnt <= CNT_W'(TMO - 1);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/ir_sampler.sv
// ir_sampler: fires the four IR emitter pairs in turn, runs the eight A2D conversions through
// the strt_cnv/cnv_cmplt handshake and publishes a coherent reading set with a one-cycle IR_vld.
//   clk, rst   clock, asynchronous active-high reset
//   bus        ir_sampler_if.master (A2D handshake, emitter enables, readings, IR_vld)
module ir_sampler
    import ir_pkg::*;
#(
    parameter int unsigned PERIOD = 65536,
    parameter int unsigned SETTLE = 1024,
    parameter int unsigned TMO    = 4096
) (
    input  logic         clk,
    input  logic         rst,
    ir_sampler_if.master bus
);

    state_t          r_state;
    logic [1:0]      r_pair;
    logic            r_strt;
    logic [2:0]      r_chnl;
    logic [3:0]      r_ir_en;
    logic            r_vld;
    logic [RD_W-1:0] r_sh_r [NUM_PAIRS];
    logic [RD_W-1:0] r_sh_l [NUM_PAIRS];
    logic [RD_W-1:0] r_ir_r [NUM_PAIRS];
    logic [RD_W-1:0] r_ir_l [NUM_PAIRS];

    logic w_tick;
    logic w_cnt_zero;
    logic w_ld_settle;
    logic w_ld_tmo;

    // Settle interval starts on sequence start and after every non-final pair completes.
    assign w_ld_settle = ((r_state == StIdle) && w_tick && bus.en) ||
                         ((r_state == StWaitL) && bus.cnv_cmplt && (r_pair != 2'd3));
    assign w_ld_tmo    = (r_state == StCnvR) || (r_state == StCnvL);

    ir_sampler_timer #(
        .PERIOD (PERIOD),
        .SETTLE (SETTLE),
        .TMO    (TMO)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .i_ld_settle (w_ld_settle),
        .i_ld_tmo    (w_ld_tmo),
        .o_tick      (w_tick),
        .o_cnt_zero  (w_cnt_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_pair  <= 2'd0;
            r_strt  <= 1'b0;
            r_chnl  <= 3'd0;
            r_ir_en <= 4'd0;
            r_vld   <= 1'b0;
            for (int i = 0; i < NUM_PAIRS; i++) begin
                r_sh_r[i] <= '0;
                r_sh_l[i] <= '0;
                r_ir_r[i] <= '0;
                r_ir_l[i] <= '0;
            end
        end else begin
            r_strt <= 1'b0;
            r_vld  <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    // Ticks in any other state are simply not looked at, hence dropped.
                    if (w_tick && bus.en) begin
                        r_state <= StSettle;
                        r_pair  <= 2'd0;
                        r_ir_en <= 4'b0001;
                    end
                end
                StSettle: begin
                    if (w_cnt_zero) begin
                        r_state <= StCnvR;
                        r_strt  <= 1'b1;
                        r_chnl  <= R_CHNL[r_pair];
                    end
                end
                StCnvR: begin
                    r_state <= StWaitR;
                end
                StWaitR: begin
                    if (bus.cnv_cmplt) begin
                        r_sh_r[r_pair] <= bus.res;
                        r_state        <= StCnvL;
                        r_strt         <= 1'b1;
                        r_chnl         <= L_CHNL[r_pair];
                    end else if (w_cnt_zero) begin
                        r_state <= StIdle;
                        r_ir_en <= 4'd0;
                    end
                end
                StCnvL: begin
                    r_state <= StWaitL;
                end
                StWaitL: begin
                    if (bus.cnv_cmplt) begin
                        r_sh_l[r_pair] <= bus.res;
                        if (r_pair == 2'd3) begin
                            r_state <= StDone;
                            r_ir_en <= 4'd0;
                        end else begin
                            r_pair  <= r_pair + 2'd1;
                            r_ir_en <= r_ir_en << 1;
                            r_state <= StSettle;
                        end
                    end else if (w_cnt_zero) begin
                        r_state <= StIdle;
                        r_ir_en <= 4'd0;
                    end
                end
                StDone: begin
                    // Whole set moves at once so the consumer never sees a partial update.
                    for (int i = 0; i < NUM_PAIRS; i++) begin
                        r_ir_r[i] <= r_sh_r[i];
                        r_ir_l[i] <= r_sh_l[i];
                    end
                    r_vld   <= 1'b1;
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign bus.strt_cnv = r_strt;
    assign bus.chnl     = r_chnl;
    assign bus.IR_en    = r_ir_en;
    assign bus.IR_vld   = r_vld;
    assign bus.IR_R0    = r_ir_r[0];
    assign bus.IR_R1    = r_ir_r[1];
    assign bus.IR_R2    = r_ir_r[2];
    assign bus.IR_R3    = r_ir_r[3];
    assign bus.IR_L0    = r_ir_l[0];
    assign bus.IR_L1    = r_ir_l[1];
    assign bus.IR_L2    = r_ir_l[2];
    assign bus.IR_L3    = r_ir_l[3];

endmodule
